// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 6-digit common-anode
// 7-segment display showing HH:MM:SS.
//
// Each digit gets one slot of DIV = CLK_HZ/SCAN_HZ cycles. The first
// BLANK_CYCLES cycles of every slot keep all anodes off to prevent ghosting.
// All six digits and the decimal-point mask are captured once per frame, at
// the start of slot 0, so a counter rollover never shows torn values.
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking. Slot 5
// (hour tens) then stays dark when its captured digit is 0.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   D_SEC_ONE .. D_HOUR_TEN  BCD digits for slots 0..5
//   DP_MASK      bit i = 1 lights the decimal point of digit i
//   AN           active-low anode enables, bit i = digit i (registered)
//   SEG          active-low segments, SEG[0]=a .. SEG[6]=g (registered)
//   DP           active-low decimal point (registered)
//   FRAME        one-cycle pulse when a new snapshot is taken (registered)
module seg7_scan_driver #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] D_SEC_ONE,
    input  logic [3:0] D_SEC_TEN,
    input  logic [3:0] D_MIN_ONE,
    input  logic [3:0] D_MIN_TEN,
    input  logic [3:0] D_HOUR_ONE,
    input  logic [3:0] D_HOUR_TEN,
    input  logic [5:0] DP_MASK,
    output logic [5:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);

    localparam int unsigned DIV        = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned IDX_W      = 3;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [5:0][3:0]       snap_q, snap_d;
    logic [5:0]            dpm_q, dpm_d;

    logic                  load;
    logic                  in_blank;
    logic                  dark;
    logic [3:0]            cur_digit;
    logic [5:0]            an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic                  frame_d;

    // Active-low BCD to segment decode; invalid codes show a dash (g only).
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    // Blanking window at the start of each slot; absent when BLANK_CYCLES is 0.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
    end

    // Next-state and next-output logic.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        snap_d    = snap_q;
        dpm_d     = dpm_q;
        an_d      = 6'h3F;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        load      = (cnt_q == '0) && (idx_q == '0);
        frame_d   = load;

        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            snap_d = {D_HOUR_TEN, D_HOUR_ONE, D_MIN_TEN, D_MIN_ONE, D_SEC_TEN, D_SEC_ONE};
            dpm_d  = DP_MASK;
        end

        // Use the incoming snapshot so a zero-length blank shows fresh digits.
        cur_digit = snap_d[idx_q];
        dark      = in_blank;
`ifdef SEG7_LZB_EN
        if ((idx_q == IDX_W'(NUM_DIGITS - 1)) && (snap_d[NUM_DIGITS-1] == 4'd0)) begin
            dark = 1'b1;
        end
`endif

        if (!dark) begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = decode(cur_digit);
            dp_d  = ~dpm_d[idx_q];
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            dpm_q  <= '0;
            AN     <= 6'h3F;
            SEG    <= 7'h7F;
            DP     <= 1'b1;
            FRAME  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            dpm_q  <= dpm_d;
            AN     <= an_d;
            SEG    <= seg_d;
            DP     <= dp_d;
            FRAME  <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with DIV=10, BLANK_CYCLES=2.
// Stimulus pushes the expected post-edge outputs into a scoreboard queue;
// a monitor on the falling edge pops and compares them.
module tb_seg7_scan_driver;

    localparam int DIV_T   = 10;
    localparam int BLANK_T = 2;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    localparam exp_t RST_EXP = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1, frame: 1'b0};

    logic       CLK;
    logic       RST_N;
    logic [3:0] din [6];
    logic [5:0] dpm;
    logic [5:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       FRAME;

    exp_t       sb [$];
    int         checks;
    int         failures;
    int         k;
    logic [3:0] snap [6];
    logic [5:0] snap_dpm;

    seg7_scan_driver #(
        .CLK_HZ      (100),
        .SCAN_HZ     (10),
        .BLANK_CYCLES(BLANK_T)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .D_SEC_ONE (din[0]),
        .D_SEC_TEN (din[1]),
        .D_MIN_ONE (din[2]),
        .D_MIN_TEN (din[3]),
        .D_HOUR_ONE(din[4]),
        .D_HOUR_TEN(din[5]),
        .DP_MASK   (dpm),
        .AN        (AN),
        .SEG       (SEG),
        .DP        (DP),
        .FRAME     (FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compare every falling edge against the scoreboard.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({AN, SEG, DP, FRAME} !== e) begin
                failures++;
                $display("FAIL out t=%0t k=%0d got an=%h seg=%h dp=%b frame=%b exp an=%h seg=%h dp=%b frame=%b",
                         $time, k, AN, SEG, DP, FRAME, e.an, e.seg, e.dp, e.frame);
            end
        end
        checks++;
        assert ($countones(~AN) <= 1) else begin
            failures++;
            $display("FAIL onehot t=%0t got an=%h exp at most one low bit", $time, AN);
        end
    end

    // Advance one edge and push the expected outputs for that edge.
    task automatic tick(input bit assert_rst);
        exp_t e;
        int   c;
        int   s;
        bit   blank;
        @(posedge CLK);
        if (!RST_N || assert_rst) begin
            e = RST_EXP;
        end else begin
            k++;
            c = (k - 1) % DIV_T;
            s = ((k - 1) / DIV_T) % 6;
            if (c == 0 && s == 0) begin
                for (int i = 0; i < 6; i++) snap[i] = din[i];
                snap_dpm = dpm;
            end
            e.frame = (c == 0 && s == 0);
            e.an    = 6'h3F;
            e.seg   = 7'h7F;
            e.dp    = 1'b1;
            blank   = (c < BLANK_T);
`ifdef SEG7_LZB_EN
            if (s == 5 && snap[5] == 4'd0) blank = 1'b1;
`endif
            if (!blank) begin
                e.an  = ~(6'(1) << s);
                e.seg = SEG_TAB[snap[s]];
                e.dp  = ~snap_dpm[s];
            end
        end
        sb.push_back(e);
        #1;
        if (assert_rst) RST_N = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        k        = 0;
        RST_N    = 1'b0;
        din[0] = 4'd1; din[1] = 4'd2; din[2] = 4'd3;
        din[3] = 4'd4; din[4] = 4'd5; din[5] = 4'd0;
        dpm      = 6'b000000;
        for (int i = 0; i < 6; i++) snap[i] = 4'd0;
        snap_dpm = '0;

        // Reset state, then release between edges.
        run(3);
        RST_N = 1'b1;

        // Frame 0: digits 1,2,3,4,5,0, no decimal points.
        run(60);

        // Frame 1: minutes-ones 9, DP on digits 2 and 4; change to 0 during slot 3.
        din[2] = 4'd9;
        dpm    = 6'b010100;
        run(35);
        din[2] = 4'd0;
        run(25);

        // Frame 2: shows the 0; hour-ones changed during slot 1 must not appear yet.
        run(11);
        din[4] = 4'd7;
        run(49);

        // Frames 3..18: every code 0..15 through slot 0.
        dpm = 6'b000000;
        for (int v = 0; v < 16; v++) begin
            din[0] = 4'(v);
            run(60);
        end

        // Reset asserted mid-SHOW of slot 3, then restart with new digits.
        run(35);
        tick(1'b1);
        run(2);
        din[0] = 4'd8;
        din[3] = 4'd6;
        RST_N  = 1'b1;
        k      = 0;
        run(70);

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
